// File: rtl/bram_dp_gen_pkg.sv
// Shared constants for the parametrised dual-port memory: write-mode codes
// and the clear-sequencer state encoding.
package bram_dp_gen_pkg;

   localparam int WM_READ_FIRST  = 0;
   localparam int WM_WRITE_FIRST = 1;
   localparam int WM_NO_CHANGE   = 2;

   typedef enum logic [1:0] {
      ST_RST   = 2'd0,
      ST_CLEAR = 2'd1,
      ST_READY = 2'd2
   } state_e;

endpackage

// File: rtl/bram_dp_gen_outpipe.sv
// Per-port read pipeline: carries Q, its valid strobe and the collision flag
// through READ_LAT register stages; Q holds whenever a stage is invalid.
module bram_dp_gen_outpipe #(
   parameter int DATA_W   = 8,
   parameter int READ_LAT = 1
) (
   input  logic              clk_i,
   input  logic              rstn_i,
   input  logic              vld_i,
   input  logic [DATA_W-1:0] data_i,
   input  logic              coll_i,
   output logic [DATA_W-1:0] q_o,
   output logic              qv_o,
   output logic              coll_o
);

   localparam int STAGES = (READ_LAT == 2) ? 2 : 1;

   logic [STAGES-1:0]             vld_pipe_q;
   logic [STAGES-1:0]             coll_pipe_q;
   logic [STAGES-1:0][DATA_W-1:0] dat_pipe_q;

   always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
         vld_pipe_q  <= '0;
         coll_pipe_q <= '0;
         dat_pipe_q  <= '0;
      end else begin
         vld_pipe_q[0]  <= vld_i;
         coll_pipe_q[0] <= coll_i;
         if (vld_i) dat_pipe_q[0] <= data_i;
         // Later stages only load when the stage before them carries new data.
         for (int i = 1; i < STAGES; i++) begin
            vld_pipe_q[i]  <= vld_pipe_q[i-1];
            coll_pipe_q[i] <= coll_pipe_q[i-1];
            if (vld_pipe_q[i-1]) dat_pipe_q[i] <= dat_pipe_q[i-1];
         end
      end
   end

   assign q_o    = dat_pipe_q[STAGES-1];
   assign qv_o   = vld_pipe_q[STAGES-1];
   assign coll_o = coll_pipe_q[STAGES-1];

endmodule

// File: rtl/bram_dp_gen.sv
// True dual-port memory with per-bit write masks, selectable write mode,
// same-address collision arbitration and an optional power-on clear sequencer.
module bram_dp_gen
   import bram_dp_gen_pkg::*;
#(
   parameter int ADDR_W     = 11,
   parameter int DATA_W     = 8,
   parameter int READ_LAT   = 1,
   parameter int WR_MODE    = 0,
   parameter int INIT_CLEAR = 0
) (
   input  logic              clk_i,
   input  logic              rstn_i,
   input  logic [ADDR_W-1:0] a0_i,
   input  logic [ADDR_W-1:0] a1_i,
   input  logic [DATA_W-1:0] d0_i,
   input  logic [DATA_W-1:0] d1_i,
   input  logic              we0_i,
   input  logic              we1_i,
   input  logic [DATA_W-1:0] wem0_i,
   input  logic [DATA_W-1:0] wem1_i,
   input  logic              ce0_i,
   input  logic              ce1_i,
   output logic [DATA_W-1:0] q0_o,
   output logic [DATA_W-1:0] q1_o,
   output logic              qv0_o,
   output logic              qv1_o,
   output logic              busy_o,
   output logic              coll_o
);

   localparam int DEPTH = 2 ** ADDR_W;
   localparam int NP    = 2;

   logic [DATA_W-1:0] mem [DEPTH];

   state_e            state_q;
   logic [ADDR_W-1:0] cnt_q;
   logic              busy_q;

   logic [NP-1:0][ADDR_W-1:0] addr;
   logic [NP-1:0][DATA_W-1:0] din, wem, old, own, word, rdat, q;
   logic [NP-1:0]             ce, we, acc, wr, rvld, qv, coll_p;
   logic                      acc_en, same, coll;
   logic [DATA_W-1:0]         only1;

   assign addr = {a1_i, a0_i};
   assign din  = {d1_i, d0_i};
   assign wem  = {wem1_i, wem0_i};
   assign ce   = {ce1_i, ce0_i};
   assign we   = {we1_i, we0_i};

   // Without a clear pass the ports are live as soon as reset is released.
   assign acc_en = rstn_i && (state_q == ST_READY ||
                              (state_q == ST_RST && INIT_CLEAR == 0));
   assign same   = (addr[0] == addr[1]);
   assign coll   = acc[0] && acc[1] && same && (we[0] || we[1]);
   assign only1  = wem[1] & ~wem[0];

   always_comb begin
      for (int p = 0; p < NP; p++) begin
         acc[p] = ce[p] && acc_en;
         wr[p]  = acc[p] && we[p];
         old[p] = mem[addr[p]];
         own[p] = (old[p] & ~wem[p]) | (din[p] & wem[p]);
      end
      // Port 0 owns overlapping mask bits; bits only port 1 masks take D1.
      word[0] = own[0];
      if (wr[1] && same) word[0] = (own[0] & ~only1) | (din[1] & only1);
      word[1] = (wr[0] && same) ? word[0] : own[1];
      for (int p = 0; p < NP; p++) begin
         rdat[p] = (we[p] && WR_MODE == WM_WRITE_FIRST) ? word[p] : old[p];
         rvld[p] = acc[p] && (!we[p] || WR_MODE != WM_NO_CHANGE);
      end
   end

   always_ff @(posedge clk_i) begin
      if (state_q == ST_CLEAR && rstn_i) begin
         mem[cnt_q] <= '0;
      end else begin
         for (int p = 0; p < NP; p++)
            if (wr[p]) mem[addr[p]] <= word[p];
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
         state_q <= ST_RST;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
      end else begin
         case (state_q)
            ST_RST: begin
               cnt_q <= '0;
               if (INIT_CLEAR != 0) begin
                  state_q <= ST_CLEAR;
                  busy_q  <= 1'b1;
               end else begin
                  state_q <= ST_READY;
               end
            end
            ST_CLEAR: begin
               cnt_q <= cnt_q + 1'b1;
               if (&cnt_q) begin
                  state_q <= ST_READY;
                  busy_q  <= 1'b0;
               end
            end
            default: state_q <= ST_READY;
         endcase
      end
   end

   for (genvar p = 0; p < NP; p++) begin : g_port
      bram_dp_gen_outpipe #(
         .DATA_W  (DATA_W),
         .READ_LAT(READ_LAT)
      ) u_pipe (
         .clk_i (clk_i),
         .rstn_i(rstn_i),
         .vld_i (rvld[p]),
         .data_i(rdat[p]),
         .coll_i(coll),
         .q_o   (q[p]),
         .qv_o  (qv[p]),
         .coll_o(coll_p[p])
      );
   end

   assign q0_o   = q[0];
   assign q1_o   = q[1];
   assign qv0_o  = qv[0];
   assign qv1_o  = qv[1];
   assign busy_o = busy_q;
   assign coll_o = |coll_p;

endmodule

// File: tb/tb_bram_dp_gen.sv
// Bench: three INIT_CLEAR=0 instances (READ_FIRST/lat1, WRITE_FIRST/lat2,
// NO_CHANGE/lat1) share stimulus against a word-level model; a 16-word
// INIT_CLEAR instance exercises the clear sequencer.
module tb_bram_dp_gen;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;

   // shared stimulus for instances 0..2
   logic        rstn, ce0, ce1, we0, we1;
   logic [10:0] a0, a1;
   logic [7:0]  d0, d1, wem0, wem1;
   logic [7:0]  q0 [3];
   logic [7:0]  q1 [3];
   logic        qv0 [3];
   logic        qv1 [3];
   logic        coll [3];
   logic        busy [3];

   for (genvar g = 0; g < 3; g++) begin : g_dut
      bram_dp_gen #(
         .ADDR_W(11), .DATA_W(8), .READ_LAT((g == 1) ? 2 : 1),
         .WR_MODE(g), .INIT_CLEAR(0)
      ) u_dut (
         .clk_i(clk), .rstn_i(rstn),
         .a0_i(a0), .a1_i(a1), .d0_i(d0), .d1_i(d1),
         .we0_i(we0), .we1_i(we1), .wem0_i(wem0), .wem1_i(wem1),
         .ce0_i(ce0), .ce1_i(ce1),
         .q0_o(q0[g]), .q1_o(q1[g]), .qv0_o(qv0[g]), .qv1_o(qv1[g]),
         .busy_o(busy[g]), .coll_o(coll[g])
      );
   end

   // clear-sequencer instance
   logic       xrstn, xce0, xce1, xwe0, xwe1;
   logic [3:0] xa0, xa1;
   logic [7:0] xd0, xd1, xwem0, xwem1, xq0, xq1;
   logic       xqv0, xqv1, xbusy, xcoll;

   bram_dp_gen #(
      .ADDR_W(4), .DATA_W(8), .READ_LAT(1), .WR_MODE(0), .INIT_CLEAR(1)
   ) u_clr (
      .clk_i(clk), .rstn_i(xrstn),
      .a0_i(xa0), .a1_i(xa1), .d0_i(xd0), .d1_i(xd1),
      .we0_i(xwe0), .we1_i(xwe1), .wem0_i(xwem0), .wem1_i(xwem1),
      .ce0_i(xce0), .ce1_i(xce1),
      .q0_o(xq0), .q1_o(xq1), .qv0_o(xqv0), .qv1_o(xqv1),
      .busy_o(xbusy), .coll_o(xcoll)
   );

   // ---------------- reference model ----------------
   logic [7:0] mem_m [2048];
   logic [7:0] eq [3][2];
   bit         ev [3][2];
   bit         ec [3];
   logic [7:0] pq [2];
   bit         pv [2];
   bit         pc;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Q/QV of one access by write-mode rules; nw is the word after this cycle's writes.
   function automatic void res(input int mode, input bit acc, input bit we,
                               input logic [7:0] old, input logic [7:0] nw,
                               output bit v, output logic [7:0] q);
      v = 1'b0;
      q = old;
      if (acc) begin
         if (!we || mode == 0) v = 1'b1;
         else if (mode == 1) begin v = 1'b1; q = nw; end
      end
   endfunction

   task automatic idle();
      ce0 = 0; ce1 = 0; we0 = 0; we1 = 0;
      a0 = '0; a1 = '0; d0 = '0; d1 = '0; wem0 = '0; wem1 = '0;
   endtask

   task automatic set0(input bit ce, input bit we, input logic [10:0] a,
                       input logic [7:0] d, input logic [7:0] m);
      ce0 = ce; we0 = we; a0 = a; d0 = d; wem0 = m;
   endtask

   task automatic set1(input bit ce, input bit we, input logic [10:0] a,
                       input logic [7:0] d, input logic [7:0] m);
      ce1 = ce; we1 = we; a1 = a; d1 = d; wem1 = m;
   endtask

   // One clock: model the presented accesses, clock, then compare all three instances.
   task automatic tick(input bit rst_c, input bit do_chk);
      logic [7:0] old0, old1;
      bit         acc0, acc1, cl;
      bit         rv [3][2];
      logic [7:0] rq [3][2];
      bit         cv [2];
      logic [7:0] cq [2];
      bit         cc;
      rstn = !rst_c;
      acc0 = !rst_c && ce0;
      acc1 = !rst_c && ce1;
      old0 = mem_m[a0];
      old1 = mem_m[a1];
      cl   = acc0 && acc1 && (a0 == a1) && (we0 || we1);
      // port 1 first, then port 0 on top: port 0 wins overlapping mask bits
      if (acc1 && we1) mem_m[a1] = (mem_m[a1] & ~wem1) | (d1 & wem1);
      if (acc0 && we0) mem_m[a0] = (mem_m[a0] & ~wem0) | (d0 & wem0);
      for (int d = 0; d < 3; d++) begin
         res(d, acc0, we0, old0, mem_m[a0], rv[d][0], rq[d][0]);
         res(d, acc1, we1, old1, mem_m[a1], rv[d][1], rq[d][1]);
      end
      @(posedge clk);
      #1;
      for (int d = 0; d < 3; d++) begin
         if (rst_c) begin
            for (int p = 0; p < 2; p++) begin
               ev[d][p] = 0;
               eq[d][p] = '0;
            end
            ec[d] = 0;
            if (d == 1) begin pv = '{0, 0}; pc = 0; end
         end else begin
            if (d == 1) begin
               cv = pv; cq = pq; cc = pc;
               pv = rv[1]; pq = rq[1]; pc = cl;
            end else begin
               cv = rv[d]; cq = rq[d]; cc = cl;
            end
            for (int p = 0; p < 2; p++) begin
               ev[d][p] = cv[p];
               if (cv[p]) eq[d][p] = cq[p];
            end
            ec[d] = cc;
         end
         if (do_chk) begin
            chk($sformatf("d%0d.qv0", d), qv0[d], ev[d][0]);
            chk($sformatf("d%0d.q0", d), q0[d], eq[d][0]);
            chk($sformatf("d%0d.qv1", d), qv1[d], ev[d][1]);
            chk($sformatf("d%0d.q1", d), q1[d], eq[d][1]);
            chk($sformatf("d%0d.coll", d), coll[d], ec[d]);
         end
      end
   endtask

   // ---------------- directed table (READ_FIRST, latency 1 instance) ----------------
   typedef struct {
      bit ce0; bit we0; logic [10:0] a0; logic [7:0] d0; logic [7:0] m0;
      bit ce1; bit we1; logic [10:0] a1; logic [7:0] d1; logic [7:0] m1;
      bit eqv0; logic [7:0] eq0; bit eqv1; logic [7:0] eq1; bit ecoll;
   } vec_t;

   vec_t tbl [14];

   // ---------------- clear sequencer helpers ----------------
   bit xqv_seen;

   task automatic clear_run(input int abort_at, output int n);
      n = 0;
      @(posedge clk);
      #1;
      chk("clr.busy_rise", xbusy, 1);
      n = int'(xbusy);
      for (int k = 0; k < 40; k++) begin
         if (!xbusy) break;
         if (n == abort_at) begin
            xrstn = 0;
            @(posedge clk);
            #1;
            chk("clr.busy_in_reset", xbusy, 0);
            xrstn = 1;
            return;
         end
         @(posedge clk);
         #1;
         if (xqv0) xqv_seen = 1;
         if (xbusy) n++;
      end
      xce0 = 0; xwe0 = 0;
   endtask

   task automatic clr_readall(input string tag);
      for (int i = 0; i < 16; i++) begin
         xce0 = 1; xwe0 = 0; xa0 = 4'(i);
         @(posedge clk);
         #1;
         chk($sformatf("%s.qv[%0d]", tag, i), xqv0, 1);
         chk($sformatf("%s.q[%0d]", tag, i), xq0, 8'h00);
      end
      xce0 = 0;
   endtask

   initial begin
      int n;
      idle();
      rstn = 0;
      xrstn = 0; xce0 = 0; xce1 = 0; xwe0 = 0; xwe1 = 0;
      xa0 = '0; xa1 = '0; xd0 = '0; xd1 = '0; xwem0 = '0; xwem1 = '0;
      for (int d = 0; d < 3; d++) begin
         ev[d] = '{0, 0}; eq[d] = '{8'h00, 8'h00}; ec[d] = 0;
      end
      pv = '{0, 0}; pq = '{8'h00, 8'h00}; pc = 0;

      tbl[0]  = '{1,1,11'h7FF,8'hA5,8'hFF, 0,0,11'h0,8'h00,8'h00, 1,8'h00, 0,8'h00, 0};
      tbl[1]  = '{0,0,11'h0,8'h00,8'h00,   1,0,11'h7FF,8'h00,8'h00, 0,8'h00, 1,8'hA5, 0};
      tbl[2]  = '{1,1,11'h1,8'hFF,8'hFF,   0,0,11'h0,8'h00,8'h00, 1,8'h00, 0,8'hA5, 0};
      tbl[3]  = '{1,1,11'h1,8'h00,8'h0F,   0,0,11'h0,8'h00,8'h00, 1,8'hFF, 0,8'hA5, 0};
      tbl[4]  = '{1,0,11'h1,8'h00,8'h00,   0,0,11'h0,8'h00,8'h00, 1,8'hF0, 0,8'hA5, 0};
      tbl[5]  = '{1,1,11'h2,8'h11,8'hFF,   0,0,11'h0,8'h00,8'h00, 1,8'h00, 0,8'hA5, 0};
      tbl[6]  = '{1,1,11'h2,8'h22,8'hFF,   0,0,11'h0,8'h00,8'h00, 1,8'h11, 0,8'hA5, 0};
      tbl[7]  = '{0,0,11'h0,8'h00,8'h00,   1,0,11'h2,8'h00,8'h00, 0,8'h11, 1,8'h22, 0};
      tbl[8]  = '{1,1,11'h5,8'hAA,8'hF0,   1,1,11'h5,8'h55,8'hFF, 1,8'h00, 1,8'h00, 1};
      tbl[9]  = '{1,0,11'h5,8'h00,8'h00,   0,0,11'h0,8'h00,8'h00, 1,8'hA5, 0,8'h00, 0};
      tbl[10] = '{1,1,11'h3,8'h77,8'hFF,   1,0,11'h3,8'h00,8'h00, 1,8'h00, 1,8'h00, 1};
      tbl[11] = '{0,0,11'h0,8'h00,8'h00,   1,0,11'h3,8'h00,8'h00, 0,8'h00, 1,8'h77, 0};
      tbl[12] = '{1,1,11'h4,8'h99,8'h00,   0,0,11'h0,8'h00,8'h00, 1,8'h00, 0,8'h77, 0};
      tbl[13] = '{1,0,11'h4,8'h00,8'h00,   0,0,11'h0,8'h00,8'h00, 1,8'h00, 0,8'h77, 0};

      // preload a known image, then reset the pipelines (contents survive reset)
      tick(1, 0);
      for (int i = 0; i < 9; i++) begin
         idle();
         set0(1, 1, (i == 8) ? 11'h7FF : 11'(i), 8'h00, 8'hFF);
         tick(0, 0);
      end
      idle();
      tick(1, 1);
      tick(1, 1);
      for (int d = 0; d < 3; d++) begin
         chk($sformatf("rst.d%0d.q0", d), q0[d], 8'h00);
         chk($sformatf("rst.d%0d.qv1", d), qv1[d], 0);
         chk($sformatf("rst.d%0d.busy", d), busy[d], 0);
      end

      for (int i = 0; i < 14; i++) begin
         idle();
         set0(tbl[i].ce0, tbl[i].we0, tbl[i].a0, tbl[i].d0, tbl[i].m0);
         set1(tbl[i].ce1, tbl[i].we1, tbl[i].a1, tbl[i].d1, tbl[i].m1);
         tick(0, 1);
         chk($sformatf("tbl[%0d].qv0", i), qv0[0], tbl[i].eqv0);
         chk($sformatf("tbl[%0d].q0", i), q0[0], tbl[i].eq0);
         chk($sformatf("tbl[%0d].qv1", i), qv1[0], tbl[i].eqv1);
         chk($sformatf("tbl[%0d].q1", i), q1[0], tbl[i].eq1);
         chk($sformatf("tbl[%0d].coll", i), coll[0], tbl[i].ecoll);
         // latency-2 instance sees the 0x7FF readback one cycle later
         if (i == 1) chk("lat2.qv1_early", qv1[1], 0);
         if (i == 2) begin
            chk("lat2.qv1", qv1[1], 1);
            chk("lat2.q1", q1[1], 8'hA5);
         end
      end

      // write modes on a location holding 0x11, then 0x22 written
      idle(); set0(1, 0, 11'h2, 8'h00, 8'h00); tick(0, 1);
      chk("nc.q0_loaded", q0[2], 8'h22);
      idle(); set0(1, 1, 11'h6, 8'h11, 8'hFF); tick(0, 1);
      idle(); set0(1, 1, 11'h6, 8'h22, 8'hFF); tick(0, 1);
      chk("rf.q0", q0[0], 8'h11);
      chk("rf.qv0", qv0[0], 1);
      chk("nc.q0_hold", q0[2], 8'h22);
      chk("nc.qv0", qv0[2], 0);
      chk("wf.q0_prev", q0[1], 8'h11);
      idle(); tick(0, 1);
      chk("wf.q0", q0[1], 8'h22);
      chk("wf.qv0", qv0[1], 1);

      // reset one cycle after a read on the latency-2 instance
      idle(); set1(1, 0, 11'h3, 8'h00, 8'h00); tick(0, 1);
      idle(); tick(1, 1);
      chk("flush.qv1", qv1[1], 0);
      chk("flush.q1", q1[1], 8'h00);
      tick(0, 1);
      chk("flush.qv1_after", qv1[1], 0);

      // randomized traffic on a small address window to provoke collisions
      for (int c = 0; c < 600; c++) begin
         idle();
         set0(1'($urandom), 1'($urandom),
              ($urandom_range(0, 15) == 0) ? 11'h7FF : 11'($urandom_range(0, 7)),
              8'($urandom), 8'($urandom));
         set1(1'($urandom), 1'($urandom),
              ($urandom_range(0, 15) == 0) ? 11'h7FF : 11'($urandom_range(0, 7)),
              8'($urandom), 8'($urandom));
         tick($urandom_range(0, 63) == 0, 1);
      end
      idle();

      // clear sequencer: busy length, dropped write, zeroed contents
      xqv_seen = 0;
      @(posedge clk); #1;
      chk("clr.busy_during_reset", xbusy, 0);
      xrstn = 1;
      xce0 = 1; xwe0 = 1; xa0 = 4'h3; xd0 = 8'h5A; xwem0 = 8'hFF;
      clear_run(-1, n);
      chk("clr.busy_len", n, 16);
      chk("clr.qv_during_busy", xqv_seen, 0);
      clr_readall("clr1");

      xce0 = 1; xwe0 = 1; xa0 = 4'h3; xd0 = 8'h5A; xwem0 = 8'hFF;
      @(posedge clk); #1;
      xwe0 = 0;
      @(posedge clk); #1;
      chk("clr.word3_written", xq0, 8'h5A);
      xce0 = 0;

      // reset after seven cleared words, then a full restart
      xrstn = 0;
      @(posedge clk); #1;
      xrstn = 1;
      clear_run(7, n);
      chk("clr.abort_count", n, 7);
      clear_run(-1, n);
      chk("clr.busy_len_restart", n, 16);
      clr_readall("clr2");

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/bram_dp_gen.md
# bram_dp_gen

Parametrised true dual-port on-chip memory with per-bit write masks, selectable write mode, optional output pipeline register, defined collision arbitration and an optional power-on clear sequencer. Generalises the fixed 2048x8 dual-port BRAM wrappers used by the accelerator PLM and cache tiles. Both ports share one clock. Storage is inferred, not instantiated.

## Interface
- ADDR_W, 11, address width; DEPTH = 2**ADDR_W words
- DATA_W, 8, word width; also the WEM width
- READ_LAT, 1, read latency in cycles; legal values 1 or 2
- WR_MODE, 0, write mode for both ports: 0 READ_FIRST, 1 WRITE_FIRST, 2 NO_CHANGE
- INIT_CLEAR, 0, when 1, zero every word after reset
- CLK  in  1  clock, rising edge
- RSTN  in  1  synchronous reset, active-low
- A0 / A1  in  ADDR_W  port 0 / port 1 address
- D0 / D1  in  DATA_W  write data
- WE0 / WE1  in  1  write enable
- WEM0 / WEM1  in  DATA_W  per-bit write mask; 1 = bit is written
- CE0 / CE1  in  1  port enable; no access when 0
- Q0 / Q1  out  DATA_W  read data
- QV0 / QV1  out  1  Q valid strobe, one cycle
- BUSY  out  1  clear sequencer active; both ports ignored
- COLL  out  1  same-address collision pulse, aligned with Q of the colliding access

## Operation
- Access on port p occurs when CEp=1 and BUSY=0.
- Write: mem[A] <= (mem[A] & ~WEM) | (D & WEM). WE=1 with WEM=0 leaves mem unchanged but still counts as a write for WR_MODE.
- Read (WE=0): Q <= mem[A], QV=1 after READ_LAT cycles.
- Write and Q by WR_MODE:
  - READ_FIRST: Q = old word, QV=1
  - WRITE_FIRST: Q = merged new word, QV=1
  - NO_CHANGE: Q holds, QV=0
- Q holds its last value whenever QV=0.
- Cross-port collision, defined as both CE=1, A0==A1 and at least one WE=1:
  - A reading port returns the old word.
  - Write/write: bits with WEM0=1 take D0. Bits with only WEM1=1 take D1. Port 0 wins overlaps.
  - COLL=1 for one cycle.
- FSM states:
  - RST: entered while RSTN=0. Goes to CLEAR if INIT_CLEAR=1, else to READY.
  - CLEAR: counter runs 0..DEPTH-1 writing zero, one word per cycle, BUSY=1. Goes to READY after writing DEPTH-1.
  - READY: normal operation.
- Reset mid-CLEAR restarts the counter at 0.
- Memory contents are not reset when INIT_CLEAR=0.

## Timing
- Reset values: Q0=Q1=0, QV0=QV1=0, COLL=0.
  - BUSY=0 during reset.
  - BUSY=1 from the first cycle after RSTN rises when INIT_CLEAR=1.
- Read latency:
  - READ_LAT=1: access at edge t, Q/QV valid after edge t+1.
  - READ_LAT=2: one extra register stage; Q/QV valid after edge t+2.
- Throughput: one access per port per cycle, back-to-back, no stalls.
- COLL is pipelined to match READ_LAT.
- Read-after-write, same port, consecutive cycles: the read returns the new data.
- BUSY lasts exactly DEPTH cycles. The first accepted access is on the cycle after BUSY falls.
- An access presented while BUSY=1 is dropped: no write, QV=0.
- Reset asserted with reads in flight: pipeline flushed, QV=0 on the next cycle.

## Structure
- Package bram_dp_gen_pkg holds:
  - WR_MODE constants: WM_READ_FIRST=0, WM_WRITE_FIRST=1, WM_NO_CHANGE=2
  - FSM state encoding: ST_RST, ST_CLEAR, ST_READY
- Sub-module bram_dp_gen_outpipe: one instance per port.
  - Parameters: DATA_W, READ_LAT.
  - Holds the Q/QV/collision-flag pipeline, hold-on-invalid behaviour and reset flush.
- The top level contains the storage array, write merge, collision arbitration and clear FSM/counter.

## Test plan
- Basic path, ADDR_W=11, DATA_W=8, READ_LAT=1: port 0 writes 0xA5 to address 0x7FF; port 1 reads 0x7FF the next cycle. Required: Q1=0xA5 with QV1=1 one cycle after the read. Repeat with READ_LAT=2 and require two cycles.
- Per-bit mask: location holds 0xFF; write D=0x00, WEM=0x0F. Required: a readback returns 0xF0.
- Write modes: location holds 0x11; write 0x22 with full mask.
  - READ_FIRST: Q=0x11, QV=1.
  - WRITE_FIRST: Q=0x22, QV=1.
  - NO_CHANGE: Q holds its previous value, QV=0.
- Collision: both ports write address 5 with D0=0xAA/WEM0=0xF0 and D1=0x55/WEM1=0xFF on an initial 0x00. Required: COLL pulses once and a readback returns 0xA5. A read/write collision returns the old word to the reader.
- Clear sequencer, INIT_CLEAR=1, ADDR_W=4:
  - BUSY=1 for exactly 16 cycles; a write presented during BUSY is dropped; all 16 words read back as 0.
  - RSTN pulsed low at clear count 7: BUSY restarts and lasts a full 16 cycles.
- Reset flush: with READ_LAT=2, assert RSTN=0 one cycle after a read is issued. Required: QV stays 0 and Q=0 after reset.
